// File: rtl/cle_pkg.sv
// cle_pkg: shared FSM/direction types, neighbour offsets and width helper for the labeler
package cle_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, FILL, DONE} state_t;
  typedef enum logic [2:0] {DIR_N, DIR_S, DIR_W, DIR_E, DIR_NW, DIR_NE, DIR_SW, DIR_SE} dir_t;
  // 2-bit two's-complement offsets packed by dir_t, DIR_N in the LSBs
  localparam logic [15:0] DX_TAB = 16'b01_11_01_11_01_11_00_00;
  localparam logic [15:0] DY_TAB = 16'b01_01_11_11_00_00_01_11;
  localparam int CONN4 = 4;
  localparam int CONN8 = 8;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/cle_queue.sv
// cle_queue: FIFO of pixel indices, depth 2**AW, same-cycle push and pop allowed
module cle_queue #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          empty
);
  logic [AW-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign dout = mem[rp];
  assign empty = cnt == '0;
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/cle_multi.sv
// cle_multi: BFS connected-component labeler, ROM bitmap in, component labels out to SRAM
// CLE_CLEAR_SRAM_EN: SCAN also writes label 0 for every background pixel
module cle_multi
  import cle_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int ROM_DW = 8,
  parameter int LABEL_W = 8,
  localparam int NPIX = IMG_W * IMG_H,
  localparam int NW = NPIX / ROM_DW,
  localparam int ROM_AW = clog2(NW),
  localparam int SRAM_AW = clog2(NPIX)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               conn8,
  input  logic [ROM_DW-1:0]  rom_q,
  output logic [ROM_AW-1:0]  rom_a,
  input  logic [LABEL_W-1:0] sram_q,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [LABEL_W-1:0] sram_d,
  output logic               sram_wen,
  output logic               busy,
  output logic               finish,
  output logic [LABEL_W-1:0] label_cnt,
  output logic               overflow
);
  localparam int XW = clog2(IMG_W);
  localparam int YW = clog2(IMG_H);
  localparam logic [LABEL_W-1:0] LMAX = '1;
  localparam logic [SRAM_AW-1:0] PLAST = '1;
  state_t state, state_d;
  dir_t nb;
  logic [NPIX-1:0] bitmap, visited;
  logic [ROM_AW:0] ld_cnt;
  logic [ROM_AW-1:0] widx;
  logic [ROM_DW-1:0] rom_rev;
  logic [SRAM_AW-1:0] p, cur, nidx, tgt, q_head, lbase;
  logic [XW-1:0] cx, nx;
  logic [YW-1:0] cy, ny;
  logic [1:0] dx, dy;
  logic [LABEL_W-1:0] wr_d, new_lbl;
  logic c8, ph, nvalid, last_nb, push, pop, q_empty, wr, new_comp, fill_end;
  logic unused_sram_q;
  assign unused_sram_q = ^sram_q;
  assign widx = ROM_AW'(ld_cnt - 1'b1);
  assign lbase = SRAM_AW'(widx) * SRAM_AW'(ROM_DW);
  assign rom_rev = {<<{rom_q}};
  assign new_lbl = (label_cnt == LMAX) ? LMAX : label_cnt + 1'b1;
  assign {cy, cx} = cur;
  assign dx = DX_TAB[{nb, 1'b0} +: 2];
  assign dy = DY_TAB[{nb, 1'b0} +: 2];
  assign nx = cx + XW'($signed(dx));
  assign ny = cy + YW'($signed(dy));
  assign nidx = {ny, nx};
  // coordinates wrap modulo the image size, so edge pixels must reject outward steps
  assign nvalid = !(dx == 2'b11 && cx == '0) && !(dx == 2'b01 && &cx) &&
                  !(dy == 2'b11 && cy == '0) && !(dy == 2'b01 && &cy);
  assign last_nb = nb == 3'(c8 ? CONN8 - 1 : CONN4 - 1);
  cle_queue #(.AW(SRAM_AW)) u_queue (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din(tgt), .dout(q_head), .empty(q_empty)
  );
  always_comb begin
    state_d = state;
    tgt = p;
    push = 1'b0;
    pop = 1'b0;
    wr = 1'b0;
    wr_d = label_cnt;
    new_comp = 1'b0;
    fill_end = 1'b0;
    case (state)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: state_d = (ld_cnt == (ROM_AW+1)'(NW)) ? SCAN : LOAD;
      SCAN: begin
        if (bitmap[p] && !visited[p]) begin
          {new_comp, push, wr} = 3'b111;
          wr_d = new_lbl;
          state_d = FILL;
        end else begin
`ifdef CLE_CLEAR_SRAM_EN
          wr = !bitmap[p];
          wr_d = '0;
`endif
          state_d = (p == PLAST) ? DONE : SCAN;
        end
      end
      FILL: begin
        tgt = nidx;
        pop = !ph;
        {push, wr} = {2{ph && nvalid && bitmap[nidx] && !visited[nidx]}};
        fill_end = ph && last_nb && q_empty && !push;
        state_d = fill_end ? ((p == PLAST) ? DONE : SCAN) : FILL;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      rom_a <= '0;
      sram_a <= '0;
      sram_d <= '0;
      sram_wen <= 1'b1;
      busy <= 1'b0;
      finish <= 1'b0;
      label_cnt <= '0;
      overflow <= 1'b0;
      ph <= 1'b0;
    end else begin
      state <= state_d;
      sram_wen <= !wr;
      if (wr) begin
        sram_a <= tgt;
        sram_d <= wr_d;
      end
      if (push) visited[tgt] <= 1'b1;
      if (new_comp) begin
        label_cnt <= new_lbl;
        overflow <= overflow | (label_cnt == LMAX);
      end
      if (state == IDLE && start) begin
        c8 <= conn8;
        label_cnt <= '0;
        overflow <= 1'b0;
        finish <= 1'b0;
        busy <= 1'b1;
        visited <= '0;
        ld_cnt <= '0;
        rom_a <= '0;
        p <= '0;
      end
      if (state == LOAD) begin
        ld_cnt <= ld_cnt + 1'b1;
        if (ld_cnt < (ROM_AW+1)'(NW - 1)) rom_a <= rom_a + 1'b1;
        if (ld_cnt != '0) bitmap[lbase +: ROM_DW] <= rom_rev;
      end
      if ((state == SCAN && state_d == SCAN) || fill_end) p <= p + 1'b1;
      if (state == FILL) begin
        if (!ph) begin
          cur <= q_head;
          nb <= DIR_N;
        end else nb <= dir_t'(nb + 3'd1);
        ph <= !ph ? 1'b1 : !last_nb;
      end
      if (state_d == DONE) begin
        finish <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cle_multi.sv
// tb_cle_multi: randomized and directed checks of cle_multi against a flood-fill reference model
module tb_cle_multi;
  localparam int W = 32;
  localparam int H = 32;
  localparam int NPIX = W * H;
  localparam int BASE_CYC = NPIX / 8 + 1 + NPIX;
`ifdef CLE_CLEAR_SRAM_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, conn8 = 1'b0;
  logic [7:0] rom_q, sram_d, label_cnt;
  logic [7:0] sram_q = '0;
  logic [6:0] rom_a;
  logic [9:0] sram_a;
  logic sram_wen, busy, finish, overflow;
  int errors = 0, checks = 0;
  bit img [NPIX];
  logic [7:0] rom_mem [NPIX/8];
  logic [7:0] sram_mem [NPIX];
  int wcnt [NPIX];
  int exp_lbl [NPIX];
  int exp_cnt, exp_cyc, busy_cyc, bad_px, bad_at;
  bit exp_ovf;
  logic fin0, busy0;

  cle_multi dut (
    .clk(clk), .reset(reset), .start(start), .conn8(conn8),
    .rom_q(rom_q), .rom_a(rom_a), .sram_q(sram_q), .sram_a(sram_a),
    .sram_d(sram_d), .sram_wen(sram_wen), .busy(busy), .finish(finish),
    .label_cnt(label_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom_mem[rom_a];
  always @(negedge clk) if (sram_wen === 1'b0) begin
    sram_mem[sram_a] = sram_d;
    wcnt[sram_a]++;
  end

  task automatic clear_img;
    foreach (img[p]) img[p] = 1'b0;
  endtask

  task automatic load_rom;
    for (int k = 0; k < NPIX / 8; k++)
      for (int i = 0; i < 8; i++) rom_mem[k][7-i] = img[k*8+i];
  endtask

  // raster-order component discovery with breadth-first growth over the image grid
  task automatic model(input bit c8);
    bit seen [NPIX];
    int q[$];
    int n = 0, nfg = 0;
    foreach (exp_lbl[p]) begin
      exp_lbl[p] = 0;
      seen[p] = 1'b0;
    end
    for (int p = 0; p < NPIX; p++) if (img[p]) begin
      nfg++;
      if (!seen[p]) begin
        n++;
        seen[p] = 1'b1;
        exp_lbl[p] = n > 255 ? 255 : n;
        q.push_back(p);
        while (q.size() > 0) begin
          int c;
          c = q.pop_front();
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
              int x, y;
              x = c % W + dx;
              y = c / W + dy;
              if ((dx != 0 || dy != 0) && (c8 || dx == 0 || dy == 0) &&
                  x >= 0 && x < W && y >= 0 && y < H) begin
                if (img[y*W+x] && !seen[y*W+x]) begin
                  seen[y*W+x] = 1'b1;
                  exp_lbl[y*W+x] = exp_lbl[p];
                  q.push_back(y*W+x);
                end
              end
            end
        end
      end
    end
    exp_cnt = n > 255 ? 255 : n;
    exp_ovf = n > 255;
    exp_cyc = BASE_CYC + nfg * (c8 ? 9 : 5);
  endtask

  task automatic run(input bit c8, input int mid_poke, input bit done_poke);
    int n = 0;
    foreach (wcnt[p]) begin
      wcnt[p] = 0;
      sram_mem[p] = '0;
    end
    load_rom();
    model(c8);
    @(negedge clk);
    conn8 = c8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    conn8 = ~c8;
    fin0 = finish;
    busy0 = busy;
    busy_cyc = 0;
    while (finish !== 1'b1 && n < 20000) begin
      if (busy === 1'b1) busy_cyc++;
      start = (n == mid_poke);
      @(negedge clk);
      n++;
    end
    start = done_poke;
    @(negedge clk);
    start = 1'b0;
    bad_px = 0;
    bad_at = -1;
    for (int p = 0; p < NPIX; p++) begin
      int ew;
      ew = (img[p] || CLR) ? 1 : 0;
      if (wcnt[p] != ew || (ew == 1 && sram_mem[p] !== 8'(exp_lbl[p]))) begin
        bad_px++;
        if (bad_at < 0) bad_at = p;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rom_a, sram_a, sram_d, sram_wen, busy, finish, label_cnt, overflow} !==
        {7'd0, 10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rom_a=%0d sram_a=%0d sram_d=%0d wen=%b busy=%b finish=%b cnt=%0d ovf=%b exp 0,0,0,1,0,0,0,0",
               rom_a, sram_a, sram_d, sram_wen, busy, finish, label_cnt, overflow);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero;
    clear_img();
    run(1'b0, -1, 1'b0);
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL zero finish got=%b exp=1", finish); end
    checks++; if (busy0 !== 1'b1 || fin0 !== 1'b0) begin errors++; $display("FAIL zero start_flags got busy=%b finish=%b exp busy=1 finish=0", busy0, fin0); end
    checks++; if (label_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL zero count got=%0d ovf=%b exp=0 ovf=0", label_cnt, overflow); end
    checks++; if (busy_cyc !== BASE_CYC) begin errors++; $display("FAIL zero busy_cycles got=%0d exp=%0d", busy_cyc, BASE_CYC); end
    checks++; if (bad_px !== 0) begin errors++; $display("FAIL zero sram bad_px=%0d first=%0d got=%0d writes=%0d exp=%0d", bad_px, bad_at, sram_mem[bad_at], wcnt[bad_at], exp_lbl[bad_at]); end
  endtask

  task automatic test_diag;
    clear_img();
    img[0] = 1'b1;
    img[W+1] = 1'b1;
    run(1'b0, -1, 1'b0);
    checks++; if (label_cnt !== 8'd2) begin errors++; $display("FAIL diag4 count got=%0d exp=2", label_cnt); end
    checks++; if (sram_mem[0] !== 8'd1 || sram_mem[W+1] !== 8'd2) begin errors++; $display("FAIL diag4 labels got=%0d,%0d exp=1,2", sram_mem[0], sram_mem[W+1]); end
    checks++; if (bad_px !== 0) begin errors++; $display("FAIL diag4 sram bad_px=%0d first=%0d exp=0", bad_px, bad_at); end
    run(1'b1, -1, 1'b0);
    checks++; if (label_cnt !== 8'd1) begin errors++; $display("FAIL diag8 count got=%0d exp=1", label_cnt); end
    checks++; if (sram_mem[0] !== 8'd1 || sram_mem[W+1] !== 8'd1) begin errors++; $display("FAIL diag8 labels got=%0d,%0d exp=1,1", sram_mem[0], sram_mem[W+1]); end
    checks++; if (busy_cyc !== BASE_CYC + 18) begin errors++; $display("FAIL diag8 busy_cycles got=%0d exp=%0d", busy_cyc, BASE_CYC + 18); end
  endtask

  task automatic test_wrap;
    clear_img();
    img[W-1] = 1'b1;
    img[W] = 1'b1;
    run(1'b1, -1, 1'b0);
    checks++; if (label_cnt !== 8'd2) begin errors++; $display("FAIL wrap count got=%0d exp=2", label_cnt); end
    checks++; if (sram_mem[W-1] !== 8'd1 || sram_mem[W] !== 8'd2) begin errors++; $display("FAIL wrap labels got=%0d,%0d exp=1,2", sram_mem[W-1], sram_mem[W]); end
  endtask

  task automatic test_checker;
    foreach (img[p]) img[p] = ((p % W + p / W) % 2) == 0;
    run(1'b0, -1, 1'b0);
    checks++; if (label_cnt !== 8'd255 || overflow !== 1'b1) begin errors++; $display("FAIL checker count got=%0d ovf=%b exp=255 ovf=1", label_cnt, overflow); end
    checks++; if (sram_mem[NPIX-1] !== 8'd255) begin errors++; $display("FAIL checker late_label got=%0d exp=255", sram_mem[NPIX-1]); end
    checks++; if (bad_px !== 0) begin errors++; $display("FAIL checker sram bad_px=%0d first=%0d got=%0d exp=%0d", bad_px, bad_at, sram_mem[bad_at], exp_lbl[bad_at]); end
    checks++; if (busy_cyc !== BASE_CYC + 512 * 5) begin errors++; $display("FAIL checker busy_cycles got=%0d exp=%0d", busy_cyc, BASE_CYC + 512 * 5); end
  endtask

  task automatic test_all_ones;
    foreach (img[p]) img[p] = 1'b1;
    run(1'b1, -1, 1'b0);
    checks++; if (label_cnt !== 8'd1 || overflow !== 1'b0) begin errors++; $display("FAIL ones count got=%0d ovf=%b exp=1 ovf=0", label_cnt, overflow); end
    checks++; if (bad_px !== 0) begin errors++; $display("FAIL ones sram bad_px=%0d first=%0d got=%0d writes=%0d exp=1 once", bad_px, bad_at, sram_mem[bad_at], wcnt[bad_at]); end
    checks++; if (busy_cyc !== BASE_CYC + NPIX * 9) begin errors++; $display("FAIL ones busy_cycles got=%0d exp=%0d", busy_cyc, BASE_CYC + NPIX * 9); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 3; it++) begin
      int dens;
      bit c8;
      dens = $urandom_range(55, 15);
      c8 = 1'($urandom_range(1));
      foreach (img[p]) img[p] = $urandom_range(99) < dens;
      run(c8, -1, 1'b0);
      checks++; if (label_cnt !== 8'(exp_cnt) || overflow !== exp_ovf) begin errors++; $display("FAIL random%0d count got=%0d ovf=%b exp=%0d ovf=%b", it, label_cnt, overflow, exp_cnt, exp_ovf); end
      checks++; if (bad_px !== 0) begin errors++; $display("FAIL random%0d sram bad_px=%0d first=%0d got=%0d exp=%0d", it, bad_px, bad_at, sram_mem[bad_at], exp_lbl[bad_at]); end
      checks++; if (busy_cyc !== exp_cyc) begin errors++; $display("FAIL random%0d busy_cycles got=%0d exp=%0d", it, busy_cyc, exp_cyc); end
    end
  endtask

  task automatic test_back_to_back;
    foreach (img[p]) img[p] = $urandom_range(99) < 35;
    run(1'b0, 600, 1'b1);
    checks++; if (label_cnt !== 8'(exp_cnt) || bad_px !== 0) begin errors++; $display("FAIL b2b result got cnt=%0d bad_px=%0d exp cnt=%0d bad_px=0", label_cnt, bad_px, exp_cnt); end
    checks++; if (busy_cyc !== exp_cyc) begin errors++; $display("FAIL b2b busy_cycles got=%0d exp=%0d", busy_cyc, exp_cyc); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || finish !== 1'b1) begin errors++; $display("FAIL b2b done_start got busy=%b finish=%b exp busy=0 finish=1", busy, finish); end
    run(1'b0, -1, 1'b0);
    checks++; if (fin0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL b2b restart got finish=%b busy=%b exp finish=0 busy=1", fin0, busy0); end
  endtask

  task automatic test_reset_mid;
    int wsum = 0;
    foreach (img[p]) img[p] = 1'b1;
    load_rom();
    @(negedge clk);
    conn8 = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (400) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid in_flight busy got=%b exp=1", busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({rom_a, sram_a, sram_d, sram_wen, busy, finish, label_cnt, overflow} !==
        {7'd0, 10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid outputs got rom_a=%0d sram_a=%0d sram_d=%0d wen=%b busy=%b finish=%b cnt=%0d ovf=%b exp 0,0,0,1,0,0,0,0",
               rom_a, sram_a, sram_d, sram_wen, busy, finish, label_cnt, overflow);
    end
    foreach (wcnt[p]) wcnt[p] = 0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    foreach (wcnt[p]) wsum += wcnt[p];
    checks++; if (wsum !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid quiet got writes=%0d busy=%b exp writes=0 busy=0", wsum, busy); end
    clear_img();
    img[0] = 1'b1;
    img[W+1] = 1'b1;
    img[5*W+7] = 1'b1;
    img[5*W+8] = 1'b1;
    run(1'b0, -1, 1'b0);
    checks++; if (label_cnt !== 8'd3 || bad_px !== 0) begin errors++; $display("FAIL rstmid rerun got cnt=%0d bad_px=%0d exp cnt=3 bad_px=0", label_cnt, bad_px); end
    checks++; if (sram_mem[5*W+8] !== 8'd3) begin errors++; $display("FAIL rstmid rerun_label got=%0d exp=3", sram_mem[5*W+8]); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_diag();
    test_wrap();
    test_checker();
    test_all_ones();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
